// File: rtl/islem_besleyici_if.sv
// Command, data-memory and arithmetic-unit signals of the islem_besleyici dispatcher.
// The master modport is the dispatcher side; the slave modport is the surrounding system.
interface islem_besleyici_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src1;
  logic [ADDR_W-1:0] cmd_src2;
  logic [ADDR_W-1:0] cmd_dst;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  logic [DATA_W-1:0] sayi1;
  logic [DATA_W-1:0] sayi2;
  logic [1:0]        islem_turu;
  logic [ADDR_W-1:0] adres_temp;
  logic              enable;
  logic [DATA_W-1:0] sonuc;
  logic              islem_bitti;

  logic              busy;
  logic              done;
  logic              timeout_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst,
    input  mem_rd_data, sonuc, islem_bitti,
    output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output sayi1, sayi2, islem_turu, adres_temp, enable, busy, done, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst,
    output mem_rd_data, sonuc, islem_bitti,
    input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  sayi1, sayi2, islem_turu, adres_temp, enable, busy, done, timeout_err
  );
endinterface

// File: rtl/islem_besleyici.sv
// Command dispatcher feeding the FP arithmetic unit: read two operands, start the unit, write back.
// Optional WAIT watchdog enabled by defining ISLEM_TIMEOUT_EN.
module islem_besleyici #(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  islem_besleyici_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_CAP2,
    S_START,
    S_WAIT,
    S_WB
`ifdef ISLEM_TIMEOUT_EN
    , S_ABORT
`endif
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit WAIT counter");
  end

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic [DATA_W-1:0] op1_q, op2_q, res_q;

`ifdef ISLEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q;

  // Cleared in START so the first WAIT cycle counts as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_START) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= bus.cmd_op;
            src1_q <= bus.cmd_src1;
            src2_q <= bus.cmd_src2;
            dst_q  <= bus.cmd_dst;
          end
        end
        S_RD2:   op1_q <= bus.mem_rd_data;
        S_CAP2:  op2_q <= bus.mem_rd_data;
        S_WAIT:  if (bus.islem_bitti) res_q <= bus.sonuc;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    bus.cmd_ready   = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.enable      = 1'b0;
    bus.done        = 1'b0;
    bus.timeout_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = S_RD1;
      end
      S_RD1: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = src1_q;
        state_d         = S_RD2;
      end
      S_RD2: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = src2_q;
        state_d         = S_CAP2;
      end
      S_CAP2:  state_d = S_START;
      S_START: begin
        bus.enable = 1'b1;
        state_d    = S_WAIT;
      end
      // Only WAIT listens to islem_bitti, so a stale done from a free-running unit cannot finish early.
      S_WAIT: begin
        if (bus.islem_bitti) begin
          state_d = S_WB;
`ifdef ISLEM_TIMEOUT_EN
        end else if (wait_cnt_q == TO_LAST) begin
          state_d = S_ABORT;
`endif
        end
      end
      S_WB: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = dst_q;
        bus.mem_wr_data = res_q;
        bus.done        = 1'b1;
        state_d         = S_IDLE;
      end
`ifdef ISLEM_TIMEOUT_EN
      S_ABORT: begin
        bus.timeout_err = 1'b1;
        state_d         = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sayi1      = op1_q;
  assign bus.sayi2      = op2_q;
  assign bus.islem_turu = op_q;
  assign bus.adres_temp = dst_q;

endmodule

// File: tb/tb_islem_besleyici.sv
// Scoreboard bench for islem_besleyici with a memory model and a delayed-done arithmetic unit model.
// Define ISLEM_TIMEOUT_EN for both RTL and bench to exercise the WAIT watchdog.
module tb_islem_besleyici;

  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [1:0]    op;
    logic [AW-1:0] dst;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  islem_besleyici_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  islem_besleyici #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: one-cycle read latency, plus a preload port for the bench.
  logic [DW-1:0] mem [0:8191];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // Arithmetic unit model: result queued by the bench, done pulse unit_delay cycles after enable.
  logic [DW-1:0] unit_res_q [$];
  int            unit_delay = 26;
  bit            unit_mute;
  logic          unit_bitti = 1'b0;
  logic          spur_bitti;
  logic          upend = 1'b0;
  int            ucount = 0;
  logic [DW-1:0] ures = '0;
  always @(posedge clk) begin
    unit_bitti <= 1'b0;
    bus.sonuc  <= 32'hDEAD_BEEF;
    if (bus.enable) begin
      upend  <= 1'b1;
      ucount <= unit_delay - 2;
      ures   <= (unit_res_q.size() > 0) ? unit_res_q.pop_front() : 32'hDEAD_BEEF;
    end else if (upend) begin
      if (ucount == 0) begin
        upend <= 1'b0;
        if (!unit_mute) begin
          unit_bitti <= 1'b1;
          bus.sonuc  <= ures;
        end
      end else begin
        ucount <= ucount - 1;
      end
    end
  end
  assign bus.islem_bitti = unit_bitti | spur_bitti;

  // Scoreboard and monitors, all sampled on the falling edge.
  wr_t           exp_wr [$];
  op_t           exp_op [$];
  logic [AW-1:0] rd_log [$];
  int acc_cyc = 0, last_done_cyc = 0, last_en_cyc = 0, last_wr_cyc = 0, last_ub_cyc = 0;
  int done_cnt = 0, wr_cnt = 0, to_cnt = 0;
  bit ready_pending = 1'b0;

  always @(negedge clk) begin : mon
    wr_t w;
    op_t o;
    if (ready_pending) begin
      check("ready_after_done", 32'(bus.cmd_ready), 32'd1);
      ready_pending = 1'b0;
    end
    if (bus.busy === 1'b1 && bus.cmd_valid) check("ready_busy", 32'(bus.cmd_ready), 32'd0);
    if (bus.cmd_valid && bus.cmd_ready === 1'b1) acc_cyc = cyc;
    if (unit_bitti) last_ub_cyc = cyc;
    if (bus.mem_rd_en === 1'b1) rd_log.push_back(bus.mem_rd_addr);
    if (bus.enable === 1'b1) begin
      last_en_cyc = cyc;
      check("en_lat", 32'(cyc - acc_cyc), 32'd4);
      if (exp_op.size() == 0) check("en_unexp", 32'd1, 32'd0);
      else begin
        o = exp_op.pop_front();
        check("sayi1", bus.sayi1, o.s1);
        check("sayi2", bus.sayi2, o.s2);
        check("islem_turu", 32'(bus.islem_turu), 32'(o.op));
        check("adres_temp", 32'(bus.adres_temp), 32'(o.dst));
      end
    end
    if (bus.mem_wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("rdwr_excl", 32'(bus.mem_rd_en), 32'd0);
      check("done_with_wr", 32'(bus.done), 32'd1);
      check("wb_lat", 32'(cyc - last_ub_cyc), 32'd1);
      if (exp_wr.size() == 0) check("wr_unexp", 32'(bus.mem_wr_addr), 32'hFFFF_FFFF);
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(bus.mem_wr_addr), 32'(w.addr));
        check("wr_data", bus.mem_wr_data, w.data);
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      ready_pending = 1'b1;
    end
    if (bus.timeout_err === 1'b1) begin
`ifdef ISLEM_TIMEOUT_EN
      to_cnt++;
      check("to_lat", 32'(cyc - acc_cyc), 32'd69);
`else
      check("to_spur", 32'(bus.timeout_err), 32'd0);
`endif
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Drive one command and hold cmd_valid until accepted; returns one step after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic [AW-1:0] d, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                      input logic [DW-1:0] res, input bit exp_write);
    bit got = 1'b0;
    exp_op.push_back('{s1: e1, s2: e2, op: op, dst: d});
    if (exp_write) exp_wr.push_back('{addr: d, data: res});
    unit_res_q.push_back(res);
    bus.cmd_valid = 1'b1; bus.cmd_op = op;
    bus.cmd_src1 = s1; bus.cmd_src2 = s2; bus.cmd_dst = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    rst = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = '0;
    bus.cmd_src1 = '0; bus.cmd_src2 = '0; bus.cmd_dst = '0;
    spur_bitti = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; unit_mute = 1'b0;
    poke(13'd10, 32'h3F80_0000);
    poke(13'd11, 32'h4000_0000);
    poke(13'd5,  32'hC0A0_0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_enable", 32'(bus.enable), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_sayi1", bus.sayi1, 32'd0);
    check("rst_adres", 32'(bus.adres_temp), 32'd0);
    @(posedge clk); #1;

    // Add: 1.0 + 2.0, done 26 cycles after enable
    unit_delay = 26; d0 = done_cnt; w0 = wr_cnt;
    send(2'b00, 13'd10, 13'd11, 13'd20, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    wait_done(100);
    check("add_mem20", mem[20], 32'h4040_0000);
    check("add_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("add_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check("add_en_to_wr", 32'(last_wr_cyc - last_en_cyc), 32'd27);

    // Back-to-back with cmd_valid held high
    unit_delay = 3;
    send(2'b01, 13'd10, 13'd11, 13'd21, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1);
    send(2'b11, 13'd11, 13'd10, 13'd22, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0001, 1'b1);
    check("b2b_gap", 32'(acc_cyc - last_done_cyc), 32'd1);
    wait_done(100);
    check("b2b_mem22", mem[22], 32'h4000_0001);

    // Spurious islem_bitti in IDLE, RD1 and START
    unit_delay = 10;
    spur_bitti = 1'b1; @(posedge clk); #1 spur_bitti = 1'b0;
    @(negedge clk);
    check("spur_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    send(2'b10, 13'd11, 13'd10, 13'd23, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    spur_bitti = 1'b1;
    @(posedge clk); #1 spur_bitti = 1'b0;
    repeat (2) @(posedge clk);
    #1 spur_bitti = 1'b1;
    @(posedge clk); #1 spur_bitti = 1'b0;
    wait_done(100);
    check("spur_en_to_wr", 32'(last_wr_cyc - last_en_cyc), 32'd11);

    // Same source address
    unit_delay = 4; rd_log.delete();
    send(2'b00, 13'd5, 13'd5, 13'd30, 32'hC0A0_0000, 32'hC0A0_0000, 32'hC120_0000, 1'b1);
    wait_done(100);
    check("same_rd_cnt", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("same_rd0", 32'(rd_log[0]), 32'd5);
      check("same_rd1", 32'(rd_log[1]), 32'd5);
    end

    // Reset in the first WAIT cycle; the unit's later done must be ignored
    unit_delay = 20; d0 = done_cnt; w0 = wr_cnt;
    send(2'b01, 13'd10, 13'd11, 13'd24, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_enable", 32'(bus.enable), 32'd0);
    check("mrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_sayi1", bus.sayi1, 32'd0);
    check("mrst_sayi2", bus.sayi2, 32'd0);
    check("mrst_turu", 32'(bus.islem_turu), 32'd0);
    repeat (30) @(negedge clk);
    check("mrst_idle_busy", 32'(bus.busy), 32'd0);
    check("mrst_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;

`ifdef ISLEM_TIMEOUT_EN
    // Unit never answers: one timeout pulse, no write, back to IDLE
    unit_mute = 1'b1; d0 = done_cnt; w0 = wr_cnt;
    send(2'b11, 13'd10, 13'd11, 13'd25, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0);
    repeat (80) @(negedge clk);
    check("to_cnt", 32'(to_cnt), 32'd1);
    check("to_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    check("to_idle", 32'(bus.busy), 32'd0);
    unit_mute = 1'b0;
    @(posedge clk); #1;
`endif

    check("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    check("sb_op_empty", 32'(exp_op.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
